// File: rtl/game_event_decoder_pkg.sv
// Shared codes and types for the game event decoder: match state codes,
// event codes and the packed FIFO event record.
package game_pkg;

    typedef enum logic [1:0] {
        GS_START = 2'd0,
        GS_SERVE = 2'd1,
        GS_RALLY = 2'd2,
        GS_END   = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_START = 3'd1,
        EV_SERVE = 3'd2,
        EV_RALLY = 3'd3,
        EV_END   = 3'd4,
        EV_POINT = 3'd5
    } evt_code_e;

    typedef struct packed {
        logic [2:0] code;
        logic [5:0] data;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    // Evaluated in 4 bits so that 7 -> 0 is never mistaken for a +1 step.
    function automatic logic is_step(input logic [2:0] cur, input logic [2:0] prev);
        return {1'b0, cur} == ({1'b0, prev} + 4'd1);
    endfunction

endpackage

// File: rtl/game_event_decoder_if.sv
// Event stream interface between the decoder and its consumers.
// evt_ts exists only when GAME_EVT_TIMESTAMP_EN is defined.
interface game_event_decoder_if #(
    parameter int DEPTH = 8
`ifdef GAME_EVT_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
);
    logic                     evt_valid;
    logic                     evt_ready;
    logic [2:0]               evt_type;
    logic [5:0]               evt_data;
    logic [$clog2(DEPTH):0]   evt_level;
`ifdef GAME_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]          evt_ts;
`endif

    modport master (
        output evt_valid, evt_type, evt_data, evt_level,
`ifdef GAME_EVT_TIMESTAMP_EN
        output evt_ts,
`endif
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_type, evt_data, evt_level,
`ifdef GAME_EVT_TIMESTAMP_EN
        input  evt_ts,
`endif
        output evt_ready
    );
endinterface

// File: rtl/game_event_decoder_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
module game_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (level == '0);
        full    = (level == LVL_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/game_event_decoder.sv
// Turns match-state changes and score steps into queued events with a phase counter.
// Optional per-event timestamps are enabled by defining GAME_EVT_TIMESTAMP_EN.
module game_event_decoder
    import game_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
`ifdef GAME_EVT_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 game_state,
    input  logic                       who_win,
    input  logic [2:0]                 player_score,
    input  logic [2:0]                 computer_score,
    game_event_decoder_if.master       evt,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic [CNT_W-1:0]           phase_cnt
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef GAME_EVT_TIMESTAMP_EN
    localparam int W = EVT_W + TS_W;
    logic [TS_W-1:0] ts_cnt;
`else
    localparam int W = EVT_W;
`endif

    logic [1:0]       prev_state;
    logic [2:0]       prev_pscore;
    logic [2:0]       prev_cscore;
    logic             state_chg;
    logic             point;
    evt_t             st_evt;
    evt_t             pt_evt;
    logic [W-1:0]     st_ent;
    logic [W-1:0]     pt_ent;
    logic [W-1:0]     pend;
    logic [W-1:0]     pend_nx;
    logic             pend_valid;
    logic             pend_valid_nx;
    logic             push;
    logic [W-1:0]     push_data;
    logic             pop;
    logic             collide_drop;
    logic             set_ovf;
    logic [W-1:0]     head;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    evt_t             head_evt;

    always_comb begin
        state_chg = (game_state != prev_state);
        point     = is_step(player_score, prev_pscore) || is_step(computer_score, prev_cscore);

        st_evt.code = {1'b0, game_state} + 3'd1;
        case (game_state)
            GS_SERVE: st_evt.data = {5'b0, who_win};
            GS_END:   st_evt.data = {player_score, computer_score};
            default:  st_evt.data = '0;
        endcase
        pt_evt.code = EV_POINT;
        pt_evt.data = {player_score, computer_score};

`ifdef GAME_EVT_TIMESTAMP_EN
        st_ent = {ts_cnt, st_evt};
        pt_ent = {ts_cnt, pt_evt};
`else
        st_ent = st_evt;
        pt_ent = pt_evt;
`endif
    end

    // One push per cycle: a waiting pending entry always goes first, and at most
    // one leftover event is kept; a second leftover (the state event) is dropped.
    always_comb begin
        push          = 1'b0;
        push_data     = pend;
        pend_valid_nx = 1'b0;
        pend_nx       = pend;
        collide_drop  = 1'b0;
        if (pend_valid) begin
            push = 1'b1;
            if (point) begin
                pend_valid_nx = 1'b1;
                pend_nx       = pt_ent;
                collide_drop  = state_chg;
            end else if (state_chg) begin
                pend_valid_nx = 1'b1;
                pend_nx       = st_ent;
            end
        end else if (point) begin
            push      = 1'b1;
            push_data = pt_ent;
            if (state_chg) begin
                pend_valid_nx = 1'b1;
                pend_nx       = st_ent;
            end
        end else if (state_chg) begin
            push      = 1'b1;
            push_data = st_ent;
        end
    end

    always_comb begin
        pop           = !empty && evt.evt_ready;
        set_ovf       = collide_drop || (push && full && !pop);
        head_evt      = head[EVT_W-1:0];
        evt.evt_valid = !empty;
        evt.evt_level = level;
        evt.evt_type  = empty ? '0 : head_evt.code;
        evt.evt_data  = empty ? '0 : head_evt.data;
`ifdef GAME_EVT_TIMESTAMP_EN
        evt.evt_ts    = empty ? '0 : head[W-1:EVT_W];
`endif
    end

    game_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_state  <= '0;
            prev_pscore <= '0;
            prev_cscore <= '0;
            pend        <= '0;
            pend_valid  <= 1'b0;
            ovf         <= 1'b0;
            phase_cnt   <= '0;
        end else begin
            prev_state  <= game_state;
            prev_pscore <= player_score;
            prev_cscore <= computer_score;
            pend        <= pend_nx;
            pend_valid  <= pend_valid_nx;
            if (set_ovf)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (state_chg)            phase_cnt <= '0;
            else if (phase_cnt != '1) phase_cnt <= phase_cnt + 1'b1;
        end
    end

`ifdef GAME_EVT_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 1'b1;
    end
`endif
endmodule
